// File: rtl/pcs_rx_block_sync_pkg.sv
// Shared PCS receive definitions: sync header codes, encoded block width
// and the block-lock state encoding.
package pcs_rx_block_sync_pkg;

    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;
    localparam int unsigned BLOCK_W   = 66;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_SLIP
    } lock_state_e;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_gearbox.sv
// 32-to-66 bit receive gearbox: LSB-first bit buffer, one block out per
// cycle at most, with a one-bit slip used by the lock FSM to realign.
module pcs_rx_gearbox
    import pcs_rx_block_sync_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    input  logic        word_vld_i,
    input  logic        slip_i,
    output logic        emit_o,
    output logic [1:0]  emit_hdr_o,
    output logic        blk_vld_o,
    output logic [1:0]  blk_hdr_o,
    output logic [63:0] blk_data_o
);

    localparam int unsigned BUF_W = BLOCK_W + 31;

    logic [BUF_W-1:0] buf_q, buf_d, acc;
    logic [6:0]       cnt_q, cnt_d, acc_cnt;
    logic             vld_q, vld_d;
    logic [1:0]       hdr_q, hdr_d;
    logic [63:0]      data_q, data_d;
    logic             emit;

    // Bits above the count are kept zero, so appending is a plain OR.
    // Taking the oldest 66 bits of the post-append buffer yields the same
    // block as removing before appending; the slip always acts last.
    always_comb begin
        acc     = buf_q;
        acc_cnt = cnt_q;
        if (word_vld_i) begin
            acc     = buf_q | (BUF_W'(word_i) << cnt_q);
            acc_cnt = cnt_q + 7'd32;
        end
        emit   = (acc_cnt >= 7'(BLOCK_W));
        buf_d  = acc;
        cnt_d  = acc_cnt;
        vld_d  = emit;
        hdr_d  = hdr_q;
        data_d = data_q;
        if (emit) begin
            hdr_d  = acc[1:0];
            data_d = acc[65:2];
            buf_d  = acc >> BLOCK_W;
            cnt_d  = acc_cnt - 7'(BLOCK_W);
        end
        if (slip_i && (cnt_d != '0)) begin
            buf_d = buf_d >> 1;
            cnt_d = cnt_d - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            hdr_q  <= '0;
            data_q <= '0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            hdr_q  <= hdr_d;
            data_q <= data_d;
        end
    end

    assign emit_o     = emit;
    assign emit_hdr_o = acc[1:0];
    assign blk_vld_o  = vld_q;
    assign blk_hdr_o  = hdr_q;
    assign blk_data_o = data_q;

endmodule

// File: rtl/pcs_rx_block_sync.sv
// PCS receive block synchroniser: gearbox plus sync-header lock FSM that
// slips the gearbox one bit at a time until 66-bit framing is found.
module pcs_rx_block_sync
    import pcs_rx_block_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned INVALID_MAX = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [1:0]            o_sync_hdr,
    output logic [63:0]           o_data,
    output logic                  o_valid,
    output logic                  o_block_lock
);

    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] INV_LIM  = CNT_W'(INVALID_MAX);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d, cnt_inc;
    logic [CNT_W-1:0] invld_q, invld_d, inv_inc;
    logic             lock_q, lock_d;
    logic             emit, hdr_ok;
    logic [1:0]       emit_hdr;

    pcs_rx_gearbox u_gearbox (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .word_i     (i_rx_data),
        .word_vld_i (i_rx_valid),
        .slip_i     (state_q == ST_SLIP),
        .emit_o     (emit),
        .emit_hdr_o (emit_hdr),
        .blk_vld_o  (o_valid),
        .blk_hdr_o  (o_sync_hdr),
        .blk_data_o (o_data)
    );

    // The FSM judges each block on the edge that emits it, so a slip lands
    // before the next block is framed.
    always_comb begin
        hdr_ok   = hdr_valid(emit_hdr);
        cnt_inc  = (sh_cnt_q == '1) ? sh_cnt_q : sh_cnt_q + 1'b1;
        inv_inc  = (hdr_ok || (invld_q == '1)) ? invld_q : invld_q + 1'b1;
        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        invld_d  = invld_q;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (emit) begin
                    if (!hdr_ok) begin
                        state_d = ST_SLIP;
                    end else if (cnt_inc >= LOCK_LIM) begin
                        state_d  = ST_LOCKED;
                        sh_cnt_d = '0;
                        invld_d  = '0;
                    end else begin
                        sh_cnt_d = cnt_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (emit) begin
                    sh_cnt_d = cnt_inc;
                    invld_d  = inv_inc;
                    if (inv_inc >= INV_LIM) begin
                        state_d = ST_SLIP;
                    end else if (cnt_inc >= LOCK_LIM) begin
                        sh_cnt_d = '0;
                        invld_d  = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_UNLOCKED;
                sh_cnt_d = '0;
                invld_d  = '0;
            end
        endcase
        lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_UNLOCKED;
            sh_cnt_q <= '0;
            invld_q  <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            invld_q  <= invld_d;
            lock_q   <= lock_d;
        end
    end

    assign o_block_lock = lock_q;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Scoreboard bench for pcs_rx_block_sync: serialises 66-bit TX blocks into
// 32-bit words and checks emitted blocks and lock status against a queue.
module tb_pcs_rx_block_sync;
    import pcs_rx_block_sync_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [1:0]  o_sync_hdr;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_block_lock;

    always #5 clk = ~clk;

    pcs_rx_block_sync #(
        .DATA_WIDTH  (32),
        .LOCK_CNT    (64),
        .INVALID_MAX (16)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_sync_hdr   (o_sync_hdr),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_block_lock (o_block_lock)
    );

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        bit          chk_data;
        int          lock_exp;
    } exp_t;

    exp_t sb[$];
    bit   tx_bits[$];
    bit   hist[$];
    exp_t cur;
    int   vec_cnt = 0, err_cnt = 0;
    int   blk_idx = 0, acc_bits = 0, acc_words = 0, cyc = 0;
    int   third_cyc = -1, first_cyc = -2;
    bit   mon_en = 0, allow_extra = 0, rate_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_bits(input logic [1:0] h, input logic [63:0] d);
        for (int j = 0; j < 2; j++) begin
            tx_bits.push_back(h[j]);
            hist.push_back(h[j]);
        end
        for (int j = 0; j < 64; j++) begin
            tx_bits.push_back(d[j]);
            hist.push_back(d[j]);
        end
    endtask

    task automatic push_exp(input logic [1:0] h, input logic [63:0] d, input bit cd, input int lk);
        exp_t e;
        e.hdr = h; e.data = d; e.chk_data = cd; e.lock_exp = lk;
        sb.push_back(e);
    endtask

    task automatic add_block(input logic [1:0] h, input logic [63:0] d, input int lk);
        add_bits(h, d);
        push_exp(h, d, 1'b1, lk);
    endtask

    function automatic logic [1:0] rand_hdr();
        return $urandom_range(1) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    task automatic drive(input int duty, input int stop_blk);
        logic [31:0] w;
        while (tx_bits.size() > 0 && !(stop_blk >= 0 && blk_idx >= stop_blk)) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < duty) begin
                for (int b = 0; b < 32; b++)
                    w[b] = (tx_bits.size() > 0) ? tx_bits.pop_front() : 1'b0;
                rx_data  = w;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; rx_data = '0; rst_n = 1'b0;
        mon_en = 0; allow_extra = 0; rate_chk = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_lock", 64'(o_block_lock), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_hdr", 64'(o_sync_hdr), 64'd0);
        sb.delete(); tx_bits.delete(); hist.delete();
        blk_idx = 0;
        rst_n = 1'b1;
        mon_en = 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc_bits = 0;
            acc_words = 0;
        end else if (rx_valid) begin
            acc_bits += 32;
            acc_words++;
            if (acc_words == 3) third_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n && o_valid) begin
            if (blk_idx == 0) first_cyc = cyc;
            if (sb.size() == 0) begin
                if (!allow_extra) chk("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                cur = sb.pop_front();
                chk($sformatf("hdr[%0d]", blk_idx), 64'(o_sync_hdr), 64'(cur.hdr));
                if (cur.chk_data) chk($sformatf("data[%0d]", blk_idx), o_data, cur.data);
                if (cur.lock_exp >= 0)
                    chk($sformatf("lock[%0d]", blk_idx), 64'(o_block_lock), 64'(cur.lock_exp));
                if (rate_chk)
                    chk($sformatf("count_ge66[%0d]", blk_idx),
                        64'(acc_bits >= 66 * (blk_idx + 1)), 64'd1);
            end
            blk_idx++;
        end
    end

    initial begin
        logic [63:0] d;
        logic [65:0] w;
        bit          inv;

        // Aligned stream: latency of first block and lock at the 64th block.
        do_reset();
        for (int n = 0; n < 70; n++) add_block(SYNC_DATA, {$urandom(), $urandom()}, int'(n >= 63));
        drive(100, -1);
        drain("drain_aligned");
        chk("first_latency", 64'(first_cyc), 64'(third_cyc));

        // 5-bit offset: junk ones and payload tails of ones make every
        // misaligned header 2'b11, so exactly five slips precede block 5.
        do_reset();
        for (int j = 0; j < 5; j++) tx_bits.push_back(1'b1);
        for (int n = 0; n < 5; n++) push_exp(2'b11, '0, 1'b0, 0);
        for (int n = 0; n < 72; n++) begin
            d = {$urandom(), $urandom()};
            d[63:59] = 5'b11111;
            add_bits(SYNC_DATA, d);
            if (n >= 5) push_exp(SYNC_DATA, d, 1'b1, int'(n >= 68));
        end
        drive(100, -1);
        drain("drain_offset");

        // Invalid-header windows: 15 tolerated, the 16th drops lock and slips.
        do_reset();
        allow_extra = 1;
        for (int n = 0; n < 166; n++) begin
            inv = (n >= 64 && n < 124 && ((n - 64) % 4) == 0) ||
                  (n >= 128 && n <= 158 && (n % 2) == 0);
            d = {$urandom(), $urandom()};
            if (n < 159) add_block(inv ? 2'b00 : rand_hdr(), d, int'(n >= 63 && n < 158));
            else         add_bits(rand_hdr(), d);
        end
        for (int j = 0; j < 66; j++) w[j] = hist[66 * 159 + 1 + j];
        push_exp(w[1:0], w[65:2], 1'b1, 0);
        drive(100, -1);
        drain("drain_invalid");

        // 50% valid duty: bit-exact blocks, never emitted below 66 bits.
        do_reset();
        rate_chk = 1;
        for (int n = 0; n < 40; n++) add_block(rand_hdr(), {$urandom(), $urandom()}, 0);
        drive(50, -1);
        drain("drain_duty");

        // Reset pulsed mid-lock, then relock from scratch.
        do_reset();
        for (int n = 0; n < 80; n++) add_block(SYNC_CTRL, {$urandom(), $urandom()}, int'(n >= 63));
        drive(100, 66);
        chk("pre_reset_lock", 64'(o_block_lock), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(o_valid), 64'd0);
        chk("async_lock", 64'(o_block_lock), 64'd0);
        chk("async_data", o_data, 64'd0);
        chk("async_hdr", 64'(o_sync_hdr), 64'd0);
        mon_en = 0;
        sb.delete(); tx_bits.delete(); hist.delete();
        blk_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        for (int n = 0; n < 70; n++) add_block(rand_hdr(), {$urandom(), $urandom()}, int'(n >= 63));
        drive(100, -1);
        drain("drain_relock");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        err_cnt++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
